// File: rtl/stack_text_renderer.sv
// ============================================================================
// stack_text_renderer
// ----------------------------------------------------------------------------
// Text-mode overlay for the stack calculator display. Draws up to DEPTH stack
// entries, one per 8x16 character row starting at character row ROW0, each as
// DIGITS upper-case hex characters starting at character column COL0. Glyphs
// come from a shared external font ROM with one cycle of read latency.
//
// Stack contents and count are snapshotted on the frame tick (x == 0,
// y == VIDEO_H), so a frame never shows a half-updated stack.
//
// Optional feature, macro RENDER_CURSOR_EN:
//   defined   - the top-of-stack row (entry 0) blinks in inverse video, with a
//               half-period of BLINK_FRAMES frames.
//   undefined - no blink logic; entry 0 renders like every other entry.
//
// Ports:
//   clk                 pixel clock
//   rst_n               asynchronous active-low reset
//   stack_flat          DEPTH entries of DIGITS*4 bits, entry 0 in the LSBs
//   stack_count         number of valid entries (saturates at DEPTH)
//   x_in, y_in          pixel coordinate from the sync generator
//   de_in, hs_in, vs_in display enable and raw syncs
//   font_addr           {char_code[6:0], glyph_row[3:0]} to the font ROM
//   font_data           glyph row, one cycle after font_addr, bit 7 leftmost
//   vga_h_sync/v_sync   syncs delayed to line up with the colour
//   vga_R/G/B           4-bit colour channels
//
// Pipeline: stage 0 decodes and registers font_addr, stage 1 is the ROM read,
// stage 2 selects the pixel bit and registers the colour. Everything at the
// outputs corresponds to the inputs three cycles earlier.
// ============================================================================
module stack_text_renderer #(
    parameter int         DEPTH        = 8,
    parameter int         DIGITS       = 4,
    parameter int         COL0         = 0,
    parameter int         ROW0         = 0,
    parameter int         VIDEO_W      = 640,
    parameter int         VIDEO_H      = 480,
    parameter logic [11:0] FG          = 12'h000,
    parameter logic [11:0] BG          = 12'hFFF,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DEPTH*DIGITS*4-1:0]      stack_flat,
    input  logic [$clog2(DEPTH+1)-1:0]     stack_count,
    input  logic [9:0]                     x_in,
    input  logic [9:0]                     y_in,
    input  logic                           de_in,
    input  logic                           hs_in,
    input  logic                           vs_in,
    output logic [10:0]                    font_addr,
    input  logic [7:0]                     font_data,
    output logic                           vga_h_sync,
    output logic                           vga_v_sync,
    output logic [3:0]                     vga_R,
    output logic [3:0]                     vga_G,
    output logic [3:0]                     vga_B
);

    localparam int EW = DIGITS * 4;
    localparam int CW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Frame snapshot
    // ------------------------------------------------------------------
    logic [DEPTH*EW-1:0] r_stack_snap;
    logic [CW-1:0]       r_count_snap;
    logic                w_tick;
    logic [EW-1:0]       w_entries [DEPTH];

    assign w_tick = (x_in == 10'd0) && (y_in == 10'(VIDEO_H));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
            assign w_entries[gi] = r_stack_snap[gi*EW +: EW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stack_snap <= '0;
            r_count_snap <= '0;
        end else if (w_tick) begin
            r_stack_snap <= stack_flat;
            r_count_snap <= (stack_count > CW'(DEPTH)) ? CW'(DEPTH) : stack_count;
        end
    end

    // ------------------------------------------------------------------
    // Blink state for the top-of-stack row
    // ------------------------------------------------------------------
    logic w_blink_phase;

`ifdef RENDER_CURSOR_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FCW-1:0] r_frame_cnt;
    logic           r_blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_blink_phase = r_blink_phase;
`else
    assign w_blink_phase = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 0: cell decode
    // ------------------------------------------------------------------
    // Coordinates are widened to 32 bits so that offsets below ROW0/COL0
    // wrap to huge values and fail the range tests instead of aliasing.
    logic [31:0] w_x32, w_y32, w_col32, w_row32, w_ent_idx, w_dig_idx;
    logic        w_is_text;
    logic        w_is_inv;
    logic [EW-1:0] w_entry;
    logic [3:0]  w_nib;
    logic [6:0]  w_char;

    assign w_x32     = {22'd0, x_in};
    assign w_y32     = {22'd0, y_in};
    assign w_col32   = {25'd0, x_in[9:3]};
    assign w_row32   = {26'd0, y_in[9:4]};
    assign w_ent_idx = w_row32 - 32'(ROW0);
    assign w_dig_idx = w_col32 - 32'(COL0);

    always_comb begin
        w_is_text = (w_x32 < 32'(VIDEO_W)) && (w_y32 < 32'(VIDEO_H))
                 && (w_row32 >= 32'(ROW0)) && (w_ent_idx < 32'(r_count_snap))
                 && (w_col32 >= 32'(COL0)) && (w_dig_idx < 32'(DIGITS));

        w_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_idx == 32'(i)) w_entry = w_entries[i];
        end

        // Digit 0 is the most significant nibble.
        w_nib = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_dig_idx == 32'(k)) w_nib = w_entry[(DIGITS-1-k)*4 +: 4];
        end

        w_char = (w_nib < 4'd10) ? (7'h30 + {3'd0, w_nib})
                                 : (7'h37 + {3'd0, w_nib});

        w_is_inv = w_is_text && w_blink_phase && (w_ent_idx == 32'd0);
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [10:0] r_font_addr;
    logic        r_text_s1, r_text_s2;
    logic        r_inv_s1,  r_inv_s2;
    logic [2:0]  r_xpix_s1, r_xpix_s2;
    logic        r_de_s1,   r_de_s2;
    logic        r_hs_s1,   r_hs_s2;
    logic        r_vs_s1,   r_vs_s2;

    assign font_addr = r_font_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_font_addr <= '0;
            r_text_s1   <= 1'b0;
            r_inv_s1    <= 1'b0;
            r_xpix_s1   <= '0;
            r_de_s1     <= 1'b0;
            r_hs_s1     <= 1'b1;
            r_vs_s1     <= 1'b1;
            r_text_s2   <= 1'b0;
            r_inv_s2    <= 1'b0;
            r_xpix_s2   <= '0;
            r_de_s2     <= 1'b0;
            r_hs_s2     <= 1'b1;
            r_vs_s2     <= 1'b1;
        end else begin
            // Stage 0 -> 1
            r_font_addr <= w_is_text ? {w_char, y_in[3:0]} : 11'd0;
            r_text_s1   <= w_is_text;
            r_inv_s1    <= w_is_inv;
            r_xpix_s1   <= x_in[2:0];
            r_de_s1     <= de_in;
            r_hs_s1     <= hs_in;
            r_vs_s1     <= vs_in;
            // Stage 1 -> 2 (ROM read in flight)
            r_text_s2   <= r_text_s1;
            r_inv_s2    <= r_inv_s1;
            r_xpix_s2   <= r_xpix_s1;
            r_de_s2     <= r_de_s1;
            r_hs_s2     <= r_hs_s1;
            r_vs_s2     <= r_vs_s1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pixel select and colour register
    // ------------------------------------------------------------------
    logic        w_pix_on;
    logic [11:0] w_colour;

    always_comb begin
        // ROM data is only meaningful for text cells; others stay BG.
        w_pix_on = r_text_s2 && font_data[3'd7 - r_xpix_s2];
        if (!r_de_s2)
            w_colour = 12'h000;
        else if (w_pix_on ^ r_inv_s2)
            w_colour = FG;
        else
            w_colour = BG;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_R      <= 4'd0;
            vga_G      <= 4'd0;
            vga_B      <= 4'd0;
            vga_h_sync <= 1'b1;
            vga_v_sync <= 1'b1;
        end else begin
            vga_R      <= w_colour[11:8];
            vga_G      <= w_colour[7:4];
            vga_B      <= w_colour[3:0];
            vga_h_sync <= r_hs_s2;
            vga_v_sync <= r_vs_s2;
        end
    end

endmodule
